// File: rtl/wb_stage_2way.sv
// wb_stage_2way: dual-lane writeback stage.
// Registers the results of the two execution lanes and drives the two register
// file write ports. Lane 2 always holds the younger instruction, so when both
// lanes write the same destination only lane 2's write is kept. Writes to x0
// are dropped. Every valid instruction accepted here counts as retired, and the
// counter saturates at its maximum value instead of wrapping.
// All outputs come straight from flops, so there is no combinational path from
// any input to any output.
module wb_stage_2way #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             l1_valid,
    input  logic             l1_regwrite,
    input  logic [4:0]       l1_rd,
    input  logic [XLEN-1:0]  l1_data,
    input  logic             l2_valid,
    input  logic             l2_regwrite,
    input  logic [4:0]       l2_rd,
    input  logic [XLEN-1:0]  l2_data,
    output logic             Wen1,
    output logic [4:0]       Rd_addr1,
    output logic [XLEN-1:0]  write_data1,
    output logic             Wen2,
    output logic [4:0]       Rd_addr2,
    output logic [XLEN-1:0]  write_data2,
    output logic             waw_kill,
    output logic [CNT_W-1:0] retire_cnt
);

    // Stage registers
    logic             r_wen1;
    logic [4:0]       r_addr1;
    logic [XLEN-1:0]  r_data1;
    logic             r_wen2;
    logic [4:0]       r_addr2;
    logic [XLEN-1:0]  r_data2;
    logic             r_waw_kill;
    logic [CNT_W-1:0] r_retire_cnt;

    // Combinational decode of the current lane inputs
    logic             w_acc;
    logic             w_w1;
    logic             w_w2;
    logic             w_waw;
    logic [1:0]       w_inc;
    logic [CNT_W:0]   w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_next;

    // Decode acceptance, per-lane write intent, WAW conflict and the retire increment
    always_comb begin
        w_acc = 1'b0;
        w_w1  = 1'b0;
        w_w2  = 1'b0;
        w_waw = 1'b0;
        w_inc = 2'd0;
        // Flush wins over stall: either one blocks acceptance
        if (!flush && !stall) begin
            w_acc = 1'b1;
        end else begin
            w_acc = 1'b0;
        end
        // A lane writes only if valid, regwrite and not targeting x0
        w_w1  = l1_valid & l1_regwrite & (l1_rd != 5'd0);
        w_w2  = l2_valid & l2_regwrite & (l2_rd != 5'd0);
        // Same destination in both lanes: younger lane 2 wins
        w_waw = w_w1 & w_w2 & (l1_rd == l2_rd);
        // Retire count ignores regwrite and rd, only validity matters
        w_inc = {1'b0, l1_valid} + {1'b0, l2_valid};
    end

    // Saturating next value of the retire counter
    always_comb begin
        w_cnt_sum  = {1'b0, r_retire_cnt} + {{(CNT_W-1){1'b0}}, w_inc};
        w_cnt_next = r_retire_cnt;
        // Carry out of CNT_W bits means the true sum exceeds the maximum
        if (w_cnt_sum[CNT_W]) begin
            w_cnt_next = {CNT_W{1'b1}};
        end else begin
            w_cnt_next = w_cnt_sum[CNT_W-1:0];
        end
    end

    // Write-enable and WAW pulse registers: single-cycle per accepted instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen1     <= 1'b0;
            r_wen2     <= 1'b0;
            r_waw_kill <= 1'b0;
        end else if (w_acc) begin
            r_wen1     <= w_w1 & ~w_waw;
            r_wen2     <= w_w2;
            r_waw_kill <= w_waw;
        end else begin
            r_wen1     <= 1'b0;
            r_wen2     <= 1'b0;
            r_waw_kill <= 1'b0;
        end
    end

    // Address/data registers: load on every accept, hold while stalled or flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr1 <= 5'd0;
            r_data1 <= {XLEN{1'b0}};
            r_addr2 <= 5'd0;
            r_data2 <= {XLEN{1'b0}};
        end else if (w_acc) begin
            r_addr1 <= l1_rd;
            r_data1 <= l1_data;
            r_addr2 <= l2_rd;
            r_data2 <= l2_data;
        end else begin
            r_addr1 <= r_addr1;
            r_data1 <= r_data1;
            r_addr2 <= r_addr2;
            r_data2 <= r_data2;
        end
    end

    // Retired-instruction counter: advances only on accepted cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= {CNT_W{1'b0}};
        end else if (w_acc) begin
            r_retire_cnt <= w_cnt_next;
        end else begin
            r_retire_cnt <= r_retire_cnt;
        end
    end

    assign Wen1        = r_wen1;
    assign Rd_addr1    = r_addr1;
    assign write_data1 = r_data1;
    assign Wen2        = r_wen2;
    assign Rd_addr2    = r_addr2;
    assign write_data2 = r_data2;
    assign waw_kill    = r_waw_kill;
    assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage_2way.sv
// Self-checking bench for wb_stage_2way: directed scenarios followed by random
// traffic, compared against a behavioural model of the writeback rules.
// A second instance with a 4-bit counter exercises saturation.
module tb_wb_stage_2way;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic            flush;
    logic            l1_valid;
    logic            l1_regwrite;
    logic [4:0]      l1_rd;
    logic [XLEN-1:0] l1_data;
    logic            l2_valid;
    logic            l2_regwrite;
    logic [4:0]      l2_rd;
    logic [XLEN-1:0] l2_data;

    logic            Wen1;
    logic [4:0]      Rd_addr1;
    logic [XLEN-1:0] write_data1;
    logic            Wen2;
    logic [4:0]      Rd_addr2;
    logic [XLEN-1:0] write_data2;
    logic            waw_kill;
    logic [31:0]     retire_cnt;

    logic            s_Wen1;
    logic [4:0]      s_Rd_addr1;
    logic [XLEN-1:0] s_write_data1;
    logic            s_Wen2;
    logic [4:0]      s_Rd_addr2;
    logic [XLEN-1:0] s_write_data2;
    logic            s_waw_kill;
    logic [3:0]      s_retire_cnt;

    wb_stage_2way #(.XLEN(XLEN), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .l1_valid(l1_valid), .l1_regwrite(l1_regwrite), .l1_rd(l1_rd), .l1_data(l1_data),
        .l2_valid(l2_valid), .l2_regwrite(l2_regwrite), .l2_rd(l2_rd), .l2_data(l2_data),
        .Wen1(Wen1), .Rd_addr1(Rd_addr1), .write_data1(write_data1),
        .Wen2(Wen2), .Rd_addr2(Rd_addr2), .write_data2(write_data2),
        .waw_kill(waw_kill), .retire_cnt(retire_cnt)
    );

    wb_stage_2way #(.XLEN(XLEN), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .l1_valid(l1_valid), .l1_regwrite(l1_regwrite), .l1_rd(l1_rd), .l1_data(l1_data),
        .l2_valid(l2_valid), .l2_regwrite(l2_regwrite), .l2_rd(l2_rd), .l2_data(l2_data),
        .Wen1(s_Wen1), .Rd_addr1(s_Rd_addr1), .write_data1(s_write_data1),
        .Wen2(s_Wen2), .Rd_addr2(s_Rd_addr2), .write_data2(s_write_data2),
        .waw_kill(s_waw_kill), .retire_cnt(s_retire_cnt)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Expected state of the writeback ports
    bit              m_wen1;
    bit              m_wen2;
    bit              m_kill;
    logic [4:0]      m_addr1;
    logic [4:0]      m_addr2;
    logic [XLEN-1:0] m_data1;
    logic [XLEN-1:0] m_data2;
    longint          m_cnt32;
    longint          m_cnt4;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wen1 = 0; m_wen2 = 0; m_kill = 0;
        m_addr1 = '0; m_addr2 = '0; m_data1 = '0; m_data2 = '0;
        m_cnt32 = 0; m_cnt4 = 0;
    endtask

    // Apply the writeback rules to the inputs present at one rising edge
    task automatic model_edge();
        bit     lane1_writes;
        bit     lane2_writes;
        bit     same_dest;
        longint retired;
        if (!rst_n) begin
            model_reset();
        end else if (flush || stall) begin
            m_wen1 = 0; m_wen2 = 0; m_kill = 0;
        end else begin
            lane1_writes = l1_valid && l1_regwrite && (l1_rd != 0);
            lane2_writes = l2_valid && l2_regwrite && (l2_rd != 0);
            same_dest    = lane1_writes && lane2_writes && (l1_rd == l2_rd);
            m_wen1  = lane1_writes && !same_dest;
            m_wen2  = lane2_writes;
            m_kill  = same_dest;
            m_addr1 = l1_rd;   m_data1 = l1_data;
            m_addr2 = l2_rd;   m_data2 = l2_data;
            retired = longint'(l1_valid) + longint'(l2_valid);
            m_cnt32 = (m_cnt32 + retired > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt32 + retired;
            m_cnt4  = (m_cnt4 + retired > 15) ? 15 : m_cnt4 + retired;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".Wen1"},     64'(Wen1),        64'(m_wen1));
        check_eq({tag, ".Wen2"},     64'(Wen2),        64'(m_wen2));
        check_eq({tag, ".waw_kill"}, 64'(waw_kill),    64'(m_kill));
        check_eq({tag, ".addr1"},    64'(Rd_addr1),    64'(m_addr1));
        check_eq({tag, ".addr2"},    64'(Rd_addr2),    64'(m_addr2));
        check_eq({tag, ".data1"},    write_data1,      m_data1);
        check_eq({tag, ".data2"},    write_data2,      m_data2);
        check_eq({tag, ".cnt"},      64'(retire_cnt),  64'(m_cnt32));
        check_eq({tag, ".cnt4"},     64'(s_retire_cnt), 64'(m_cnt4));
    endtask

    // One clock: model the edge, then sample 1 unit after it
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_lanes(input bit v1, input bit rw1, input logic [4:0] rd1, input logic [63:0] d1,
                             input bit v2, input bit rw2, input logic [4:0] rd2, input logic [63:0] d2);
        l1_valid = v1; l1_regwrite = rw1; l1_rd = rd1; l1_data = d1;
        l2_valid = v2; l2_regwrite = rw2; l2_rd = rd2; l2_data = d2;
    endtask

    task automatic idle_lanes();
        set_lanes(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        idle_lanes();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Outputs stay at reset values until the first accepting edge
        stall = 1'b1;
        set_lanes(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 1'b1, 5'd4, 64'h44);
        step("hold_after_reset");
        stall = 1'b0;

        // Scenario 1: two independent writes
        set_lanes(1'b1, 1'b1, 5'd5, 64'h11, 1'b1, 1'b1, 5'd6, 64'h22);
        step("t1");
        check_eq("t1.Wen1_const", 64'(Wen1), 64'd1);
        check_eq("t1.cnt_const",  64'(retire_cnt), 64'd2);
        idle_lanes();
        step("t1_idle");
        check_eq("t1_idle.Wen2_const", 64'(Wen2), 64'd0);

        // Scenario 2: WAW on x7, lane 2 wins
        set_lanes(1'b1, 1'b1, 5'd7, 64'hA, 1'b1, 1'b1, 5'd7, 64'hB);
        step("t2");
        check_eq("t2.kill_const", 64'(waw_kill), 64'd1);
        check_eq("t2.data2_const", write_data2, 64'hB);
        idle_lanes();
        step("t2_idle");

        // Scenario 3: x0 write and a non-writing instruction still retire
        set_lanes(1'b1, 1'b1, 5'd0, 64'h5, 1'b1, 1'b0, 5'd9, 64'h6);
        step("t3");
        check_eq("t3.cnt_const", 64'(retire_cnt), 64'd6);

        // Scenario 4: stall for 3 cycles, then release for a single pulse
        set_lanes(1'b1, 1'b1, 5'd12, 64'hC0DE, 1'b1, 1'b1, 5'd13, 64'hBEEF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step("t4_stall");
        stall = 1'b0;
        step("t4_release");
        idle_lanes();
        step("t4_after");
        // Flush over stall: inputs lost
        set_lanes(1'b1, 1'b1, 5'd14, 64'h1414, 1'b0, 1'b0, 5'd0, 64'h0);
        stall = 1'b1; flush = 1'b1;
        step("t4_flush");
        stall = 1'b0; flush = 1'b0;
        idle_lanes();
        step("t4_flush_after");

        // Scenario 5: 4-bit counter reaches 14, then saturates at 15
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        set_lanes(1'b1, 1'b0, 5'd1, 64'h0, 1'b1, 1'b0, 5'd2, 64'h0);
        for (int i = 0; i < 7; i++) step("t5_fill");
        check_eq("t5.cnt4_14", 64'(s_retire_cnt), 64'd14);
        step("t5_sat1");
        check_eq("t5.cnt4_15", 64'(s_retire_cnt), 64'd15);
        step("t5_sat2");
        check_eq("t5.cnt4_hold", 64'(s_retire_cnt), 64'd15);

        // Scenario 6: async reset between edges while Wen1 is high
        set_lanes(1'b1, 1'b1, 5'd20, 64'hFEED, 1'b0, 1'b0, 5'd0, 64'h0);
        step("t6_pre");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        idle_lanes();

        // Random traffic, biased toward WAW, x0 and stall/flush corners
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            set_lanes($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      5'($urandom_range(0, 7)), {$urandom, $urandom},
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      5'($urandom_range(0, 7)), {$urandom, $urandom});
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
